// File: rtl/fifo_pkg.sv
// Shared types for the fifo block: the per-cycle operation decode.
package fifo_pkg;

    // Accepted operations this cycle, encoded as {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the fifo.
interface fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;

    // Surrounding logic driving the fifo.
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, count
    );

    // The fifo itself.
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, count
    );
endinterface : fifo_if

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PW         = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [PW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the word at the write address on an accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read port is purely combinational so the head word falls through.
    assign rdata_o = mem_q[raddr_i];
endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock show-ahead FIFO: pointers, occupancy count and flags,
// with storage in fifo_mem.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input logic   clk,
    input logic   rst,
    fifo_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full, empty;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] head;
    op_e                   op;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flags come from the registered count only, so they move on edges or reset.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Acceptance uses the flags as they stand at the start of the cycle.
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;
    assign op     = op_e'({wr_acc, rd_acc});

    // Next-state for pointers and count from the accepted operations.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op)
            OP_PUSH: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + 1'b1;
            end
            OP_POP: begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_q - 1'b1;
            end
            OP_BOTH: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            default: ;
        endcase
    end

    // Pointer and count registers; reset discards everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PW         (PW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Empty FIFO presents zero rather than stale storage.
    assign bus.rd_data = empty ? '0 : head;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.count   = count_q;
endmodule : fifo

// File: tb/tb_fifo.sv
// Directed table-driven bench for fifo (DATA_WIDTH 8, DEPTH 16), plus
// hand-written sequences for wrap, simultaneous requests and async reset.
module tb_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] data;
        logic [7:0] exp_head;   // rd_data before the edge
        logic [4:0] exp_cnt;    // after the edge
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] d,
                                input logic [7:0] h, input logic [4:0] c,
                                input logic f, input logic e);
        vec_t v;
        v.wr = wr; v.rd = rd; v.data = d; v.exp_head = h;
        v.exp_cnt = c; v.exp_full = f; v.exp_empty = e;
        return v;
    endfunction

    // Drive one cycle of requests; called 1ns after a rising edge.
    task automatic drive(input logic wr, input logic rd, input logic [7:0] d);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.wr_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;

        // Reset state.
        #2;
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: pop on empty, fill, overflow, drain, pop on empty again.
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1));
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(1'b1, 1'b0, 8'(k - 1), 8'h00, 5'(k), (k == 16), 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'hAA, 8'h00, 5'd16, 1'b1, 1'b0));
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'(j), 5'(15 - j), 1'b0, (j == 15)));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1));

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].data);
            chk($sformatf("vec%0d_head", i), 32'(bus.rd_data), 32'(vecs[i].exp_head));
            tick();
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
        end

        // Interleaved push/pop across pointer wrap against a scoreboard.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 8'(8'h80 + k));
            q.push_back(8'(8'h80 + k));
            tick();
            chk($sformatf("wrap%0d_push_count", k), 32'(bus.count), 32'(q.size()));
            drive(1'b0, 1'b1, 8'h00);
            chk($sformatf("wrap%0d_head", k), 32'(bus.rd_data), 32'(q[0]));
            void'(q.pop_front());
            tick();
            chk($sformatf("wrap%0d_pop_count", k), 32'(bus.count), 32'(q.size()));
        end

        // Full with write and read together: read wins, write dropped.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i));
            tick();
        end
        chk("simfull_pre_full", 32'(bus.full), 1);
        drive(1'b1, 1'b1, 8'hEE);
        chk("simfull_head", 32'(bus.rd_data), 32'h10);
        tick();
        chk("simfull_count", 32'(bus.count), 15);
        chk("simfull_full", 32'(bus.full), 0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk($sformatf("simfull_drain%0d", i), 32'(bus.rd_data), 32'(8'h10 + i));
            tick();
        end
        chk("simfull_dropped_empty", 32'(bus.empty), 1);
        chk("simfull_dropped_rd_data", 32'(bus.rd_data), 0);

        // Empty with write and read together: write wins.
        drive(1'b1, 1'b1, 8'h55);
        tick();
        chk("simempty_count", 32'(bus.count), 1);
        chk("simempty_empty", 32'(bus.empty), 0);
        chk("simempty_head", 32'(bus.rd_data), 32'h55);

        // Mid-stream asynchronous reset, asserted away from any edge.
        drive(1'b1, 1'b0, 8'h66);
        tick();
        drive(1'b1, 1'b0, 8'h77);
        tick();
        chk("prerst_count", 32'(bus.count), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_empty", 32'(bus.empty), 1);
        chk("midrst_count", 32'(bus.count), 0);
        chk("midrst_rd_data", 32'(bus.rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 8'h3C);
        tick();
        drive(1'b1, 1'b0, 8'h3D);
        tick();
        chk("postrst_head", 32'(bus.rd_data), 32'h3C);
        chk("postrst_count", 32'(bus.count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_fifo
